// File: rtl/alu_arb_pkg.sv
// Shared types and sizing for the two-requester tinyalu arbiter.
package alu_arb_pkg;

  localparam int N_REQ  = 2;
  localparam int OPND_W = 8;
  localparam int RES_W  = 16;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Opcodes that are actually executed by tinyalu; everything else completes locally.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin grant. The pointer remembers who was served last and
// moves only when a grant is actually taken (grant implies handshake here).
module rr_arbiter
  import alu_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_idx
);

  logic r_last;
  logic w_pick;

  // Contention goes to whoever was not served last; otherwise the lone requester.
  always_comb begin
    w_pick = (&i_req) ? ~r_last : i_req[1];
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign o_grant[gi] = i_en && i_req[gi] && (w_pick == 1'(gi));
    end
  endgenerate

  assign o_idx = w_pick;

  // Pointer register; reset value makes requester 0 the favourite.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last <= 1'b1;
    end else if (|o_grant) begin
      r_last <= w_pick;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one tinyalu between two requesters. One operation in flight at a
// time: accept in IDLE, run on tinyalu in BUSY (with timeout), respond in RESP.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*OPND_W-1:0] req_a_i,
  input  logic [N_REQ*OPND_W-1:0] req_b_i,
  input  logic [N_REQ*OP_W-1:0] req_op_i,
  output logic [N_REQ-1:0]      rsp_valid_o,
  output logic [RES_W-1:0]      rsp_result_o,
  output logic                  rsp_err_o,
  output logic [OPND_W-1:0]     alu_a_o,
  output logic [OPND_W-1:0]     alu_b_o,
  output logic [OP_W-1:0]       alu_op_o,
  output logic                  alu_start_o,
  input  logic                  alu_done_i,
  input  logic [RES_W-1:0]      alu_result_i,
  output logic                  busy_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            r_state;
  state_e            w_state_next;
  logic [OPND_W-1:0] r_a;
  logic [OPND_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic              r_owner;
  logic [RES_W-1:0]  r_result;
  logic              r_err;
  logic [CW-1:0]     r_tmo_cnt;

  logic [OPND_W-1:0] w_req_a  [N_REQ];
  logic [OPND_W-1:0] w_req_b  [N_REQ];
  logic [OP_W-1:0]   w_req_op [N_REQ];
  logic [N_REQ-1:0]  w_grant;
  logic              w_grant_idx;
  logic              w_hs;
  logic              w_tmo_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req_a[gi]  = req_a_i[OPND_W*gi +: OPND_W];
      assign w_req_b[gi]  = req_b_i[OPND_W*gi +: OPND_W];
      assign w_req_op[gi] = req_op_i[OP_W*gi +: OP_W];
    end
  endgenerate

  rr_arbiter u_rr (
    .clk_i   (clk_i),
    .rst_ni  (reset_n),
    .i_req   (req_valid_i),
    .i_en    (r_state == ST_IDLE),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  // Ready equals grant, so any grant bit is a completed handshake.
  assign w_hs      = |w_grant;
  assign w_tmo_hit = (r_tmo_cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode; tinyalu lines are driven only while BUSY.
  always_comb begin
    w_state_next = r_state;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    rsp_result_o = '0;
    rsp_err_o    = 1'b0;
    alu_a_o      = '0;
    alu_b_o      = '0;
    alu_op_o     = '0;
    alu_start_o  = 1'b0;
    busy_o       = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        busy_o      = 1'b0;
        req_ready_o = w_grant;
        if (w_hs) begin
          w_state_next = is_alu_op(w_req_op[w_grant_idx]) ? ST_BUSY : ST_RESP;
        end
      end
      ST_BUSY: begin
        alu_a_o     = r_a;
        alu_b_o     = r_b;
        alu_op_o    = r_op;
        alu_start_o = 1'b1;
        if (alu_done_i || w_tmo_hit) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_o[r_owner] = 1'b1;
        rsp_result_o         = r_result;
        rsp_err_o            = r_err;
        w_state_next         = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request capture, result/error capture and BUSY timeout counting.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_owner   <= 1'b0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_tmo_cnt <= '0;
          if (w_hs) begin
            r_a      <= w_req_a[w_grant_idx];
            r_b      <= w_req_b[w_grant_idx];
            r_op     <= w_req_op[w_grant_idx];
            r_owner  <= w_grant_idx;
            // Locally completed ops: NOP is clean, unknown opcodes flag an error.
            r_result <= '0;
            r_err    <= (w_req_op[w_grant_idx] != OP_NOP) && !is_alu_op(w_req_op[w_grant_idx]);
          end
        end
        ST_BUSY: begin
          r_tmo_cnt <= r_tmo_cnt + CW'(1);
          // A done arriving on the timeout cycle still counts as success.
          if (alu_done_i) begin
            r_result <= alu_result_i;
            r_err    <= 1'b0;
          end else if (w_tmo_hit) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        default: r_tmo_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised bench for alu_arbiter with a behavioural tinyalu and a
// transaction-level reference model of grants, results and latencies.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int TMO = 8;

  logic        clk_i;
  logic        reset_n;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [15:0] req_a_i;
  logic [15:0] req_b_i;
  logic [5:0]  req_op_i;
  logic [1:0]  rsp_valid_o;
  logic [15:0] rsp_result_o;
  logic        rsp_err_o;
  logic [7:0]  alu_a_o;
  logic [7:0]  alu_b_o;
  logic [2:0]  alu_op_o;
  logic        alu_start_o;
  logic        alu_done_i;
  logic [15:0] alu_result_i;
  logic        busy_o;

  // Per-requester drive variables, each written only by its own issue call.
  logic       v0, v1;
  logic [7:0] a0, a1, b0, b1;
  logic [2:0] op0, op1;
  assign req_valid_i = {v1, v0};
  assign req_a_i     = {a1, a0};
  assign req_b_i     = {b1, b0};
  assign req_op_i    = {op1, op0};

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.TIMEOUT(TMO)) dut (
    .clk_i        (clk_i),
    .reset_n      (reset_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_op_i     (req_op_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_result_o (rsp_result_o),
    .rsp_err_o    (rsp_err_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_op_o     (alu_op_o),
    .alu_start_o  (alu_start_o),
    .alu_done_i   (alu_done_i),
    .alu_result_i (alu_result_i),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return 16'(int'(a) + int'(b));
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(int'(a) * int'(b));
      default: return 16'h0000;
    endcase
  endfunction

  // tinyalu timing: done one cycle after start for ADD/AND/XOR, three for MUL.
  function automatic int alu_delay(input logic [2:0] op);
    return (op == 3'd4) ? 3 : 1;
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Behavioural tinyalu; no_done models a hung unit.
  logic no_done;
  int   alu_cnt;
  always @(negedge clk_i) begin
    if (!alu_start_o) begin
      alu_cnt      = 0;
      alu_done_i   = 1'b0;
      alu_result_i = 16'($urandom);
    end else begin
      alu_cnt = alu_cnt + 1;
      if (!no_done && alu_cnt == alu_delay(alu_op_o) + 1) begin
        alu_done_i   = 1'b1;
        alu_result_i = ref_res(alu_op_o, alu_a_o, alu_b_o);
      end else begin
        alu_done_i   = 1'b0;
        alu_result_i = 16'($urandom);
      end
    end
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model state: one outstanding transaction at most.
  logic       m_busy = 1'b0;
  logic       m_last = 1'b1;
  logic       c_owner, c_tmo, prev_start;
  logic [2:0] c_op;
  logic [7:0] c_a, c_b;
  int         c_hs, start_cnt, wait_cnt;
  logic [1:0] g;
  logic       legal, exp_err;
  int         exp_sc;
  logic [15:0] exp_res;

  always @(negedge clk_i) begin
    if (!reset_n) begin
      m_busy     = 1'b0;
      m_last     = 1'b1;
      prev_start = 1'b0;
      start_cnt  = 0;
      wait_cnt   = 0;
    end else begin
      g = m_busy ? 2'b00 : exp_grant(req_valid_i, m_last);
      chk("busy", busy_o, m_busy);
      chk("ready", req_ready_o, g);
      if (alu_start_o) begin
        if (!prev_start) chk("start_lat", cyc - c_hs, 1);
        chk("alu_ops", {alu_op_o, alu_a_o, alu_b_o}, {c_op, c_a, c_b});
        start_cnt++;
      end else begin
        chk("alu_idle", {alu_op_o, alu_a_o, alu_b_o}, 0);
      end
      prev_start = alu_start_o;
      if (rsp_valid_o != 2'b00) begin
        if (!m_busy) begin
          chk("rsp_spurious", rsp_valid_o, 0);
        end else begin
          legal   = (c_op >= 3'd1) && (c_op <= 3'd4);
          exp_sc  = !legal ? 0 : (c_tmo ? TMO : alu_delay(c_op) + 1);
          exp_res = (legal && !c_tmo) ? ref_res(c_op, c_a, c_b) : 16'h0000;
          exp_err = (c_op != 3'd0) && (!legal || c_tmo);
          chk("rsp_owner", rsp_valid_o, c_owner ? 2'b10 : 2'b01);
          chk("rsp_result", rsp_result_o, exp_res);
          chk("rsp_err", rsp_err_o, exp_err);
          chk("start_cycles", start_cnt, exp_sc);
          chk("rsp_lat", cyc - c_hs, exp_sc + 1);
          chk("rsp_start_low", alu_start_o, 0);
          $display("txn req%0d op=%0d a=%02h b=%02h -> result=%04h err=%0d start_cycles=%0d",
                   c_owner, c_op, c_a, c_b, rsp_result_o, rsp_err_o, start_cnt);
          m_busy = 1'b0;
        end
      end else if (m_busy) begin
        wait_cnt++;
        if (wait_cnt > 100) begin
          chk("rsp_missing", 0, 1);
          m_busy = 1'b0;
        end
      end
      if (g != 2'b00) begin
        c_owner   = g[1];
        c_op      = g[1] ? op1 : op0;
        c_a       = g[1] ? a1 : a0;
        c_b       = g[1] ? b1 : b0;
        c_tmo     = no_done;
        c_hs      = cyc;
        m_busy    = 1'b1;
        m_last    = g[1];
        start_cnt = 0;
        wait_cnt  = 0;
      end
    end
  end

  task automatic issue(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (r == 0) begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else        begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_i); #1;
      if (req_ready_o[r]) begin
        @(posedge clk_i); #1;
        if (r == 0) v0 = 1'b0; else v1 = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    if (r == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(posedge clk_i); #2;
      if (!m_busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [1:0] m;
  initial begin
    reset_n = 1'b0;
    no_done = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = '0; op1 = '0;

    @(posedge clk_i); #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_result", rsp_result_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_alu", {alu_start_o, alu_op_o, alu_a_o, alu_b_o}, 0);
    chk("rst_busy", busy_o, 0);
    repeat (2) @(negedge clk_i);
    #2 reset_n = 1'b1;
    @(posedge clk_i); #1;

    // Basic ADD from requester 0.
    issue(0, 3'd1, 8'h12, 8'h34);
    wait_idle();

    // Illegal opcode from requester 1 completes locally with an error.
    issue(1, 3'd6, 8'($urandom), 8'($urandom));
    wait_idle();

    // Both requesters hammering MUL: grants must alternate.
    fork
      begin for (int k = 0; k < 4; k++) issue(0, 3'd4, 8'hFF, 8'hFF); end
      begin for (int k = 0; k < 4; k++) issue(1, 3'd4, 8'hFF, 8'hFF); end
    join
    wait_idle();

    // Hung tinyalu: timeout, then a normal request.
    no_done = 1'b1;
    issue(0, 3'd1, 8'h01, 8'h02);
    wait_idle();
    no_done = 1'b0;
    issue(1, 3'd2, 8'hF0, 8'h3C);
    wait_idle();

    // Reset in the middle of a MUL.
    issue(0, 3'd4, 8'h10, 8'h20);
    @(posedge clk_i); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_start", alu_start_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_rsp", rsp_valid_o, 0);
    repeat (2) @(negedge clk_i);
    #2 reset_n = 1'b1;
    @(posedge clk_i); #1;
    fork
      issue(1, 3'd1, 8'h01, 8'h01);
      issue(0, 3'd1, 8'h02, 8'h02);
      begin @(negedge clk_i); #1; chk("postrst_grant", req_ready_o, 2'b01); end
    join
    wait_idle();

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      m = 2'($urandom_range(1, 3));
      fork
        begin if (m[0]) issue(0, 3'($urandom), 8'($urandom), 8'($urandom)); end
        begin if (m[1]) issue(1, 3'($urandom), 8'($urandom), 8'($urandom)); end
      join
      wait_idle();
    end

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
